// File: rtl/uart_programmer.sv
// rtl/uart_programmer.sv - UART boot loader driving the upg_* memory programming port
module uart_programmer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        rx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR_TGT, HDR_LO, HDR_HI, DATA} state_t;

  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       rx_state, rx_state_nxt;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            rx_tick, byte_valid, frame_err;

  state_t          state, state_nxt;
  logic            target;
  logic [7:0]      n_lo;
  logic [15:0]     words_left;
  logic [13:0]     addr;
  logic [1:0]      byte_cnt;
  logic [23:0]     word;
  logic            strobe_set, hdr_bad, hdr_tgt_ok;

  // The start check lands half a bit in; every later sample is a full bit apart.
  assign rx_tick    = (rx_state == RX_START) ? (rx_cnt == CW'(HALF)) : (rx_cnt == CW'(CLKS_PER_BIT));
  assign hdr_tgt_ok = (rx_shift == 8'h00) || (rx_shift == 8'h01);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver next state; byte_valid / frame_err pulse in the stop-sample cycle.
  always_comb begin
    rx_state_nxt = rx_state;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s2 && rx_prev) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && bit_idx == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_nxt = RX_IDLE;
          byte_valid   = rx_s2;
          frame_err    = !rx_s2;
        end
      end
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // Receiver state, bit timer and LSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= CW'(1);
      else                                rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_IDLE) bit_idx <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
    end
  end

  // Frame decoder next state; start_pg overrides everything, including a due strobe.
  always_comb begin
    state_nxt  = state;
    strobe_set = 1'b0;
    hdr_bad    = 1'b0;
    if (start_pg) begin
      state_nxt = HDR_TGT;
    end else begin
      case (state)
        IDLE: ;
        HDR_TGT: begin
          if (byte_valid) begin
            if (hdr_tgt_ok)                state_nxt = HDR_LO;
            else if (rx_shift == 8'hFF)    state_nxt = IDLE;
            else                           hdr_bad   = 1'b1;
          end
        end
        HDR_LO: if (byte_valid) state_nxt = HDR_HI;
        HDR_HI: if (byte_valid) state_nxt = ({rx_shift, n_lo} == 16'd0) ? HDR_TGT : DATA;
        DATA: begin
          if (byte_valid && byte_cnt == 2'd3) strobe_set = 1'b1;
          if (upg_wen_o && words_left == 16'd1) state_nxt = HDR_TGT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame registers: header fields, word assembly, write strobe and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      target     <= 1'b0;
      n_lo       <= '0;
      words_left <= '0;
      addr       <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b1;
      upg_err_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      upg_wen_o <= strobe_set;
      if (strobe_set) begin
        upg_adr_o <= {target, addr};
        upg_dat_o <= {rx_shift, word};
      end
      if (start_pg) begin
        byte_cnt   <= '0;
        word       <= '0;
        upg_err_o  <= 1'b0;
        upg_done_o <= 1'b0;
      end else begin
        if (frame_err || hdr_bad) upg_err_o <= 1'b1;
        if (state == HDR_TGT && byte_valid) begin
          if (hdr_tgt_ok)          target     <= rx_shift[0];
          if (rx_shift == 8'hFF)   upg_done_o <= 1'b1;
        end
        if (state == HDR_LO && byte_valid) n_lo <= rx_shift;
        if (state == HDR_HI && byte_valid) begin
          words_left <= {rx_shift, n_lo};
          addr       <= '0;
          byte_cnt   <= '0;
        end
        if (state == DATA && byte_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0:    word[7:0]   <= rx_shift;
            2'd1:    word[15:8]  <= rx_shift;
            2'd2:    word[23:16] <= rx_shift;
            default: ;
          endcase
        end
        if (state == DATA && upg_wen_o) begin
          addr       <= addr + 14'd1;
          words_left <= words_left - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_programmer.sv
// tb/tb_uart_programmer.sv - protocol-level model bench for uart_programmer
module tb_uart_programmer;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        start_pg;
  logic        rx;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;

  uart_programmer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .rx(rx),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .upg_err_o(upg_err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_strobe_cyc = 0;
  logic prev_wen = 1'b0;

  // Protocol model: 0 idle, 1 target header, 2 count low, 3 count high, 4 data
  int          m_st;
  bit          m_tgt;
  int          m_n;
  int          m_addr;
  bit          m_done, m_err;
  logic [7:0]  m_part[$];
  logic [14:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [14:0] m_last_adr;
  logic [31:0] m_last_dat;
  logic [14:0] cap_adr[$];
  logic [31:0] cap_dat[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_tgt = 0; m_n = 0; m_addr = 0; m_done = 1; m_err = 0;
    m_part.delete(); exp_adr.delete(); exp_dat.delete();
    m_last_adr = '0; m_last_dat = '0;
  endtask

  task automatic model_start();
    m_st = 1; m_done = 0; m_err = 0; m_part.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_st)
      1: begin
        if (b == 8'h00 || b == 8'h01) begin m_tgt = b[0]; m_st = 2; end
        else if (b == 8'hFF) begin m_st = 0; m_done = 1; end
        else m_err = 1;
      end
      2: begin m_n = int'(b); m_st = 3; end
      3: begin
        m_n = m_n + 256 * int'(b);
        if (m_n == 0) m_st = 1;
        else begin m_addr = 0; m_part.delete(); m_st = 4; end
      end
      4: begin
        m_part.push_back(b);
        if (m_part.size() == 4) begin
          exp_adr.push_back({m_tgt, 14'(m_addr)});
          exp_dat.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
          m_part.delete();
          m_addr = (m_addr + 1) % 16384;
          m_n = m_n - 1;
          if (m_n == 0) m_st = 1;
        end
      end
      default: ;
    endcase
  endtask

  // Every cycle out of reset: strobes must match the model queue; adr/dat must hold.
  always @(negedge clk) begin
    if (rst) begin
      if (upg_wen_o) begin
        chk("strobe_back_to_back", 32'(prev_wen), 32'd0);
        if (exp_adr.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
          m_last_adr = upg_adr_o;
          m_last_dat = upg_dat_o;
        end else begin
          m_last_adr = exp_adr.pop_front();
          m_last_dat = exp_dat.pop_front();
        end
        cap_adr.push_back(upg_adr_o);
        cap_dat.push_back(upg_dat_o);
        last_strobe_cyc = cyc;
      end
      chk("adr", 32'(upg_adr_o), 32'(m_last_adr));
      chk("dat", upg_dat_o, m_last_dat);
      prev_wen = upg_wen_o;
    end else begin
      prev_wen = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx = 1'b0; start_cyc = cyc;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk); #1;
    rx = 1'b1;
    if (stop) model_byte(b);
    else if (rst) m_err = 1;
    repeat (3) @(negedge clk);
    chk("done", 32'(upg_done_o), 32'(m_done));
    chk("err", 32'(upg_err_o), 32'(m_err));
    chk("pending_strobes", 32'(exp_adr.size()), 32'd0);
    exp_adr.delete(); exp_dat.delete();
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_pg = 1'b1;
    @(posedge clk); #1 start_pg = 1'b0;
    model_start();
    cap_adr.delete(); cap_dat.delete();
    @(negedge clk);
    chk("start_done_low", 32'(upg_done_o), 32'd0);
    chk("start_err_clear", 32'(upg_err_o), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen"}, 32'(upg_wen_o), 32'd0);
    chk({tag, "_adr"}, 32'(upg_adr_o), 32'd0);
    chk({tag, "_dat"}, upg_dat_o, 32'd0);
    chk({tag, "_done"}, 32'(upg_done_o), 32'd1);
    chk({tag, "_err"}, 32'(upg_err_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; start_pg = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = ~rx;
    end
    @(negedge clk);
    chk_reset_vals("reset");
    rx = 1'b1;
    repeat (3) @(posedge clk); #1 rst = 1'b1;

    // bytes in IDLE are ignored
    send_list('{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    chk("idle_no_strobe", 32'(cap_adr.size()), 32'd0);

    // instruction block of two words
    pulse_start();
    send_list('{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    chk("strobe_latency", 32'(last_strobe_cyc - start_cyc), 32'd41);
    send_list('{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF});
    chk("ib_count", 32'(cap_adr.size()), 32'd2);
    if (cap_adr.size() == 2) begin
      chk("ib_adr0", 32'(cap_adr[0]), 32'h0000);
      chk("ib_dat0", cap_dat[0], 32'h12345678);
      chk("ib_adr1", 32'(cap_adr[1]), 32'h0001);
      chk("ib_dat1", cap_dat[1], 32'hDEADBEEF);
    end
    chk("ib_done", 32'(upg_done_o), 32'd1);

    // data block then an empty block
    pulse_start();
    send_list('{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'hFF});
    chk("tb_count", 32'(cap_adr.size()), 32'd1);
    if (cap_adr.size() == 1) begin
      chk("tb_adr", 32'(cap_adr[0]), 32'h4000);
      chk("tb_dat", cap_dat[0], 32'hDDCCBBAA);
    end
    chk("tb_done", 32'(upg_done_o), 32'd1);

    // framing error inside a word
    pulse_start();
    send_list('{8'h00, 8'h01, 8'h00, 8'hAA});
    send_byte(8'h55, 1'b0);
    chk("fe_err_set", 32'(upg_err_o), 32'd1);
    send_list('{8'hBB, 8'hCC, 8'hDD, 8'hFF});
    chk("fe_count", 32'(cap_adr.size()), 32'd1);
    if (cap_adr.size() == 1) begin
      chk("fe_adr", 32'(cap_adr[0]), 32'h0000);
      chk("fe_dat", cap_dat[0], 32'hDDCCBBAA);
    end
    chk("fe_err_sticky", 32'(upg_err_o), 32'd1);

    // bad target, glitch, then a normal block
    pulse_start();
    send_byte(8'h05, 1'b1);
    chk("bt_err", 32'(upg_err_o), 32'd1);
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_done", 32'(upg_done_o), 32'd0);
    chk("glitch_err", 32'(upg_err_o), 32'd1);
    send_list('{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
    chk("bt_count", 32'(cap_adr.size()), 32'd1);
    if (cap_adr.size() == 1) begin
      chk("bt_adr", 32'(cap_adr[0]), 32'h0000);
      chk("bt_dat", cap_dat[0], 32'h04030201);
    end

    // start_pg abort after two data bytes
    pulse_start();
    send_list('{8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB});
    pulse_start();
    send_list('{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF});
    chk("ab_count", 32'(cap_adr.size()), 32'd1);
    if (cap_adr.size() == 1) begin
      chk("ab_adr", 32'(cap_adr[0]), 32'h4000);
      chk("ab_dat", cap_dat[0], 32'h44332211);
    end

    // reset in the middle of a word
    pulse_start();
    send_list('{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB});
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1 rst = 1'b1;
    cap_adr.delete(); cap_dat.delete();
    send_list('{8'hCC, 8'hDD});
    chk("midrst_no_strobe", 32'(cap_adr.size()), 32'd0);
    chk("midrst_done", 32'(upg_done_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
